uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver for the serial front end:
- Recovers asynchronous frames from the `rx` pin with configurable data width, parity mode, stop-bit count and baud divisor.
- Majority-votes each bit at mid-period and reports parity, framing and break errors alongside each byte.
- Output is a one-cycle strobe with data and status, consumed directly by the downstream command parser or an RX FIFO.

## Interface
Parameters:
- `CLK_DIV`, 5208: `sclk` cycles per bit. Legal values are ≥ 8; sims use 16.
- `DATA_BITS`, 8: data bits per frame, 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.

Ports:
- `sclk`  in  1  system clock; single clock domain.
- `srst`  in  1  reset, synchronous, active-high.
- `rx`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  DATA_BITS  received word, LSB = first bit on the line.
- `po_flag`  out  1  one-cycle strobe; qualifies `rx_data` and the error flags.
- `parity_err`  out  1  parity mismatch for the word just strobed; always 0 when `PARITY`=0.
- `frame_err`  out  1  a stop bit was sampled low.
- `break_det`  out  1  all data bits, the parity bit (if any) and the first stop bit sampled low.
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- **Input synchroniser:** `s1<=rx`, `s2<=s1`, `s3<=s2`. All three reset to 1.
  - Falling edge `neg = ~s2 & s3`.
  - Vote register `v[2:0] <= {v[1:0], s2}` every cycle, reset to 3'b111.
  - Sampled bit = majority(`v`).
- **Baud counter `bcnt`:** width `$clog2(CLK_DIV)`.
  - Cleared in IDLE.
  - Otherwise counts 0..CLK_DIV-1 and wraps to 0. Each wrap marks a bit boundary.
  - Sample point is `bcnt == CLK_DIV/2`.
- **Bit counter `bidx`:** counts data bits 0..DATA_BITS-1.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE → START on `neg`. `bcnt` starts at 0 on the next cycle.
  - START, at the sample point: if the sample is 1 (glitch), go to IDLE with no strobe and no flags. Otherwise continue; advance to DATA on the wrap.
  - DATA: at each sample point, shift the sample into the MSB of the shift register, so the first bit ends up at the LSB. After DATA_BITS samples, go to PAR on the wrap if `PARITY`≠0, else to STOP.
  - PAR: at the sample point, compute `parity_err_n = ^data ^ sample ^ (PARITY==1)`, then advance on the wrap.
  - STOP: each stop bit is sampled at its sample point; any low stop sample sets `frame_err_n`.
    - After the last stop sample, go to IDLE immediately without waiting for the wrap, so a back-to-back start edge half a bit later is caught.
- **Break:** `break_det_n` = data all-zero AND parity sample 0 (if parity is enabled) AND first stop sample 0.
  - A break always also sets `frame_err`.
  - After a break the line stays low, so `neg` cannot occur and no further frame starts until `rx` returns high and falls again.
- **Outputs:** `rx_data`, `parity_err`, `frame_err` and `break_det` are registered.
  - They update in the same cycle that `po_flag` is high.
  - They hold their values until the next `po_flag`.
- **Reset:** `srst` asserted at any time, including mid-frame, forces IDLE.
  - Outputs go to 0; synchroniser and vote register go to 1.
  - The partial frame is discarded with no strobe.
  - A line held low through reset release is not taken as a start bit.

## Timing
- Let cycle E be the cycle in which `neg`=1. Let N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS and H = CLK_DIV/2.
- `po_flag` is high in cycle E + 1 + (N-1)·CLK_DIV + H + 1, for exactly one cycle.
- `busy` rises at E+1 and falls in the same cycle `po_flag` rises, or one cycle after a rejected start sample.
- Minimum acceptable start pulse is about H cycles. Pulses of at most 1 cycle are always rejected by the vote.
- Back-to-back frames with zero idle between stop and start are received without loss.

## Test plan
- **Basic byte:** CLK_DIV=16, 8N1, send 0xA5 → one `po_flag`, `rx_data`=0xA5, all errors 0, strobe at E+1+9·16+8+1 = E+154.
- **Even parity:** 8E1, send 0x03 with parity bit 0 → `parity_err`=0; then 0x03 with parity bit 1 → `parity_err`=1, `rx_data`=0x03.
- **Glitches:** a 2-cycle low pulse on idle line → no `po_flag`, `busy` back low within 8+3 cycles. A 1-cycle high glitch mid-data-bit → data unaffected.
- **Framing and break:**
  - 0x7E with stop=0 → `frame_err`=1, `break_det`=0.
  - Line held low for 20 bit times → exactly one `po_flag` with `rx_data`=0, `frame_err`=1, `break_det`=1. Next frame is received only after `rx` returns high.
- **Streaming and config:** DATA_BITS=7, STOP_BITS=2, three back-to-back frames 0x11, 0x7F, 0x00 with no idle gap → three strobes with matching data and spacing of 11·16 cycles.
- **Reset mid-frame:** assert `srst` for 1 cycle during bit 4 of a frame → no strobe, outputs 0. The next complete frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with majority-vote sampling and error flags
//   sclk       : system clock
//   srst       : synchronous active-high reset
//   rx         : asynchronous serial input, idle high
//   rx_data    : received word, first bit on the line at the LSB
//   po_flag    : one-cycle strobe qualifying rx_data and the error flags
//   parity_err : parity mismatch for the strobed word
//   frame_err  : a stop bit was sampled low
//   break_det  : data, parity and first stop bit all sampled low
//   busy       : receiver is inside a frame
module uart_rx_cfg #(
  parameter int CLK_DIV   = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 sclk,
  input  logic                 srst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 po_flag,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] SAMP_PT   = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] LAST_CNT  = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

  state_e               state_q, state_d;
  logic                 s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [2:0]           v_q, v_d;
  logic [1:0]           sv_q, sv_d;
  logic                 arm_q, arm_d;
  logic [CW-1:0]        bcnt_q, bcnt_d;
  logic [IW-1:0]        bidx_q, bidx_d;
  logic                 sidx_q, sidx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d, pz_q, pz_d, st0_q, st0_d, ferr_q, ferr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 po_flag_q, po_flag_d, parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d, break_det_q, break_det_d;

  logic neg, sample, samp_pt, wrap, first_low, brk;

  // arm_q only rises once s2 has carried a genuine high from the line after
  // reset; the reset value of the synchroniser must not fake a falling edge
  // when the line is held low through reset release.
  assign neg       = ~s2_q & s3_q & arm_q;
  assign sample    = (v_q[0] & v_q[1]) | (v_q[0] & v_q[2]) | (v_q[1] & v_q[2]);
  assign samp_pt   = (bcnt_q == SAMP_PT);
  assign wrap      = (bcnt_q == LAST_CNT);
  assign first_low = (sidx_q == 1'b0) ? ~sample : st0_q;
  assign brk       = (shreg_q == '0) & pz_q & first_low;

  always_ff @(posedge sclk) begin
    if (srst) begin
      state_q      <= S_IDLE;
      s1_q         <= 1'b1;
      s2_q         <= 1'b1;
      s3_q         <= 1'b1;
      v_q          <= 3'b111;
      sv_q         <= 2'b00;
      arm_q        <= 1'b0;
      bcnt_q       <= '0;
      bidx_q       <= '0;
      sidx_q       <= 1'b0;
      shreg_q      <= '0;
      perr_q       <= 1'b0;
      pz_q         <= 1'b1;
      st0_q        <= 1'b0;
      ferr_q       <= 1'b0;
      rx_data_q    <= '0;
      po_flag_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      v_q          <= v_d;
      sv_q         <= sv_d;
      arm_q        <= arm_d;
      bcnt_q       <= bcnt_d;
      bidx_q       <= bidx_d;
      sidx_q       <= sidx_d;
      shreg_q      <= shreg_d;
      perr_q       <= perr_d;
      pz_q         <= pz_d;
      st0_q        <= st0_d;
      ferr_q       <= ferr_d;
      rx_data_q    <= rx_data_d;
      po_flag_q    <= po_flag_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_det_q  <= break_det_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (neg) state_d = S_START;
      S_START: begin
        if (samp_pt && sample) state_d = S_IDLE;
        else if (wrap)         state_d = S_DATA;
      end
      S_DATA:  if (wrap && bidx_q == LAST_BIT) state_d = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (wrap) state_d = S_STOP;
      // leave on the last stop sample so a back-to-back start edge is not missed
      S_STOP:  if (samp_pt && sidx_q == LAST_STOP) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s1_d         = rx;
    s2_d         = s1_q;
    s3_d         = s2_q;
    v_d          = {v_q[1:0], s2_q};
    sv_d         = {sv_q[0], 1'b1};
    arm_d        = arm_q | (sv_q[1] & s2_q);
    bcnt_d       = wrap ? '0 : bcnt_q + 1'b1;
    bidx_d       = bidx_q;
    sidx_d       = sidx_q;
    shreg_d      = shreg_q;
    perr_d       = perr_q;
    pz_d         = pz_q;
    st0_d        = st0_q;
    ferr_d       = ferr_q;
    rx_data_d    = rx_data_q;
    po_flag_d    = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    break_det_d  = break_det_q;

    if (state_q == S_IDLE || state_d == S_IDLE) bcnt_d = '0;

    case (state_q)
      S_IDLE: begin
        bidx_d = '0;
        sidx_d = 1'b0;
        perr_d = 1'b0;
        pz_d   = 1'b1;
        st0_d  = 1'b0;
        ferr_d = 1'b0;
      end
      S_DATA: begin
        if (samp_pt) shreg_d = {sample, shreg_q[DATA_BITS-1:1]};
        if (wrap)    bidx_d  = bidx_q + 1'b1;
      end
      S_PAR: begin
        if (samp_pt) begin
          perr_d = (^shreg_q) ^ sample ^ ODD;
          pz_d   = ~sample;
        end
      end
      S_STOP: begin
        if (samp_pt) begin
          ferr_d = ferr_q | ~sample;
          st0_d  = first_low;
          if (sidx_q == LAST_STOP) begin
            po_flag_d    = 1'b1;
            rx_data_d    = shreg_q;
            parity_err_d = perr_q;
            frame_err_d  = ferr_q | ~sample | brk;
            break_det_d  = brk;
          end
        end
        if (wrap) sidx_d = sidx_q + 1'b1;
      end
      default: ;
    endcase
  end

  assign rx_data    = rx_data_q;
  assign po_flag    = po_flag_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - scoreboard bench for uart_rx_cfg in 8N1, 8E1 and 7O2 configurations
module tb_uart_rx_cfg;

  localparam int CLK = 16;
  localparam int H   = CLK / 2;

  typedef struct {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
    int         cyc;
  } exp_t;

  logic sclk = 1'b0;
  logic srst;
  logic rx_a, rx_b, rx_c;
  logic [7:0] d_a, d_b;
  logic [6:0] d_c;
  logic po_a, pe_a, fe_a, bk_a, busy_a;
  logic po_b, pe_b, fe_b, bk_b, busy_b;
  logic po_c, pe_c, fe_c, bk_c, busy_c;

  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  uart_rx_cfg #(.CLK_DIV(CLK), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .sclk(sclk), .srst(srst), .rx(rx_a), .rx_data(d_a), .po_flag(po_a),
    .parity_err(pe_a), .frame_err(fe_a), .break_det(bk_a), .busy(busy_a));

  uart_rx_cfg #(.CLK_DIV(CLK), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .sclk(sclk), .srst(srst), .rx(rx_b), .rx_data(d_b), .po_flag(po_b),
    .parity_err(pe_b), .frame_err(fe_b), .break_det(bk_b), .busy(busy_b));

  uart_rx_cfg #(.CLK_DIV(CLK), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
    .sclk(sclk), .srst(srst), .rx(rx_c), .rx_data(d_c), .po_flag(po_c),
    .parity_err(pe_c), .frame_err(fe_c), .break_det(bk_c), .busy(busy_c));

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive(input int u, input logic b);
    case (u)
      0:       rx_a = b;
      1:       rx_b = b;
      default: rx_c = b;
    endcase
  endtask

  // Entered and left on a negedge. gl selects a frame bit (0 = start) that
  // gets a one-cycle inverted glitch in the middle of its vote window.
  task automatic send_frame(input int u, input int nb, input int np, input int ns,
                            input logic [8:0] d, input logic pb, input logic sb,
                            input int gl, input bit push,
                            input logic epe, input logic efe, input logic ebk);
    logic [12:0] bits;
    int   n;
    exp_t e;
    n = 0;
    bits = '1;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < nb; i++) begin bits[n] = d[i]; n++; end
    if (np != 0) begin bits[n] = pb; n++; end
    for (int i = 0; i < ns; i++) begin bits[n] = sb; n++; end
    if (push) begin
      e.d   = d;
      e.pe  = epe;
      e.fe  = efe;
      e.bk  = ebk;
      e.cyc = cyc + 4 + (n - 1) * CLK + H;
      case (u)
        0:       q_a.push_back(e);
        1:       q_b.push_back(e);
        default: q_c.push_back(e);
      endcase
    end
    for (int i = 0; i < n; i++) begin
      drive(u, bits[i]);
      if (i == gl) begin
        repeat (H - 1) @(negedge sclk);
        drive(u, ~bits[i]);
        @(negedge sclk);
        drive(u, bits[i]);
        repeat (CLK - H) @(negedge sclk);
      end else begin
        repeat (CLK) @(negedge sclk);
      end
    end
  endtask

  task automatic mon(input int u, input logic [8:0] d, input logic pe, input logic fe,
                     input logic bk, input logic bz);
    exp_t e;
    bit   got;
    got = 0;
    case (u)
      0:       if (q_a.size() > 0) begin e = q_a.pop_front(); got = 1; end
      1:       if (q_b.size() > 0) begin e = q_b.pop_front(); got = 1; end
      default: if (q_c.size() > 0) begin e = q_c.pop_front(); got = 1; end
    endcase
    if (!got) begin
      chk($sformatf("u%0d_unexpected_po_flag", u), 1, 0);
    end else begin
      chk($sformatf("u%0d_rx_data", u), int'(d), int'(e.d));
      chk($sformatf("u%0d_parity_err", u), int'(pe), int'(e.pe));
      chk($sformatf("u%0d_frame_err", u), int'(fe), int'(e.fe));
      chk($sformatf("u%0d_break_det", u), int'(bk), int'(e.bk));
      chk($sformatf("u%0d_po_cycle", u), cyc, e.cyc);
      chk($sformatf("u%0d_busy_at_po", u), int'(bz), 0);
    end
  endtask

  always @(negedge sclk) begin
    if (po_a) mon(0, {1'b0, d_a}, pe_a, fe_a, bk_a, busy_a);
    if (po_b) mon(1, {1'b0, d_b}, pe_b, fe_b, bk_b, busy_b);
    if (po_c) mon(2, {2'b00, d_c}, pe_c, fe_c, bk_c, busy_c);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int p, t_hi, t_lo, bz;
    exp_t e;
    srst = 1'b1;
    rx_a = 1'b0;
    rx_b = 1'b1;
    rx_c = 1'b1;
    repeat (4) @(negedge sclk);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_po_a", int'(po_a), 0);
    chk("rst_data_a", int'(d_a), 0);
    chk("rst_flags_b", int'({pe_b, fe_b, bk_b}), 0);
    chk("rst_busy_c", int'(busy_c), 0);
    srst = 1'b0;

    bz = 0;
    repeat (60) begin
      @(negedge sclk);
      if (busy_a) bz++;
    end
    chk("low_through_reset_busy_cycles", bz, 0);
    rx_a = 1'b1;
    repeat (20) @(negedge sclk);

    send_frame(0, 8, 0, 1, 9'h0A5, 1'b0, 1'b1, -1, 1, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge sclk);

    p = cyc;
    rx_a = 1'b0;
    repeat (2) @(negedge sclk);
    rx_a = 1'b1;
    t_hi = -1;
    t_lo = -1;
    for (int k = 0; k < 30; k++) begin
      @(negedge sclk);
      if (busy_a && t_hi < 0) t_hi = cyc;
      if (!busy_a && t_hi >= 0 && t_lo < 0) t_lo = cyc;
    end
    chk("glitch_busy_rise", t_hi, p + 3);
    chk("glitch_busy_fall", t_lo, p + 3 + H + 1);

    send_frame(0, 8, 0, 1, 9'h03C, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge sclk);

    send_frame(0, 8, 0, 1, 9'h07E, 1'b0, 1'b0, -1, 1, 1'b0, 1'b1, 1'b0);
    rx_a = 1'b1;
    repeat (20) @(negedge sclk);

    p = cyc;
    e.d = 9'h000; e.pe = 1'b0; e.fe = 1'b1; e.bk = 1'b1; e.cyc = p + 4 + 9 * CLK + H;
    q_a.push_back(e);
    rx_a = 1'b0;
    repeat (20 * CLK) @(negedge sclk);
    rx_a = 1'b1;
    repeat (40) @(negedge sclk);
    send_frame(0, 8, 0, 1, 9'h081, 1'b0, 1'b1, -1, 1, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge sclk);

    fork
      send_frame(0, 8, 0, 1, 9'h0F0, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, 1'b0);
      begin
        repeat (5 * CLK + 4) @(negedge sclk);
        srst = 1'b1;
        @(negedge sclk);
        srst = 1'b0;
        chk("midrst_data_a", int'(d_a), 0);
        chk("midrst_flags_a", int'({po_a, fe_a, bk_a, pe_a}), 0);
        chk("midrst_busy_a", int'(busy_a), 0);
      end
    join
    repeat (20) @(negedge sclk);
    send_frame(0, 8, 0, 1, 9'h05A, 1'b0, 1'b1, -1, 1, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge sclk);

    send_frame(1, 8, 1, 1, 9'h003, 1'b0, 1'b1, -1, 1, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge sclk);
    send_frame(1, 8, 1, 1, 9'h003, 1'b1, 1'b1, -1, 1, 1'b1, 1'b0, 1'b0);
    repeat (20) @(negedge sclk);

    send_frame(2, 7, 1, 2, 9'h011, 1'b1, 1'b1, -1, 1, 1'b0, 1'b0, 1'b0);
    send_frame(2, 7, 1, 2, 9'h07F, 1'b0, 1'b1, -1, 1, 1'b0, 1'b0, 1'b0);
    send_frame(2, 7, 1, 2, 9'h000, 1'b1, 1'b1, -1, 1, 1'b0, 1'b0, 1'b0);
    repeat (300) @(negedge sclk);

    chk("a_strobes_missing", q_a.size(), 0);
    chk("b_strobes_missing", q_b.size(), 0);
    chk("c_strobes_missing", q_c.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
